axil_regbank: RTL and testbench
===============================

Name: axil_regbank

Overview:
Self-contained, parametrised AXI4-Lite register bank. It implements its own AW/W/B/AR/R handshake logic and needs no separate slave core. It provides a version register, a scratch register, NUM_CTRL read/write control registers with byte-strobe support and write-pulse outputs, and NUM_STAT read-only status registers. It sits between the AXI interconnect and the team's peripheral blocks (I2C engine etc.) as their control/status front end.

Parameters:
NUM_CTRL, 4, number of 32-bit RW control registers (1..16)
NUM_STAT, 4, number of 32-bit RO status registers (1..16)
MODULE_VERSION, 2, value returned by register index 0
ADDR_BITS, 7, decoded byte-address bits; register index = addr[ADDR_BITS-1:2]; requires 2+NUM_CTRL+NUM_STAT <= 2**(ADDR_BITS-2)

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
S_AXI_AWADDR  in  32  write address
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_AWPROT  in  3  ignored
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte-lane strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  32  read address
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARPROT  in  3  ignored
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
ctrl_out  out  32*NUM_CTRL  control register contents; register k in bits [32k+31:32k]
ctrl_wstb  out  NUM_CTRL  one-cycle pulse on register k the cycle after it is updated
stat_in  in  32*NUM_STAT  status inputs; register k in bits [32k+31:32k]

Behaviour:
- Single clock clk. Reset is synchronous, active-low (resetn), sampled on the rising edge.
- Register map by index: 0 = version (RO); 1 = scratch (RW); 2..1+NUM_CTRL = ctrl[0..] (RW); next NUM_STAT = stat[0..] (RO); all higher indices unmapped.
- Responses: OKAY=0, SLVERR=2, DECERR=3.
  - Unmapped index, read or write: DECERR.
  - Write to a RO register: SLVERR, no state change.
  - DECERR reads return RDATA=0.
- Reset values:
  - All READY/VALID outputs = 0.
  - BRESP = RRESP = 0, RDATA = 0.
  - scratch, all ctrl = 0; ctrl_wstb = 0.
  - Both state machines go to IDLE; any in-flight transaction is abandoned with no response.
- Write FSM, states W_IDLE / W_RESP:
  - W_IDLE: AWREADY=1 until the address is captured; WREADY=1 until the data is captured. AW and W are accepted in either order or together, each latched on its own handshake.
  - On the edge after both are held: target register updated, BRESP set, BVALID=1, go to W_RESP.
  - Byte lane i is written only if WSTRB[i]=1. WSTRB=0000 gives OKAY, no data change, but ctrl_wstb still pulses.
  - W_RESP: AWREADY=WREADY=0; hold BVALID/BRESP stable until BREADY. On that handshake go to W_IDLE with BVALID=0; ready outputs re-assert the next cycle.
- Read FSM, states R_IDLE / R_RESP:
  - R_IDLE: ARREADY=1. On the AR handshake edge: register RDATA/RRESP, RVALID=1, ARREADY=0, go to R_RESP.
  - Read latency is one cycle.
  - R_RESP: hold RDATA/RRESP/RVALID stable until RREADY handshake, then go to R_IDLE.
  - Status (non-sticky) is sampled from stat_in at the AR handshake edge.
- Read and write FSMs are independent and may be active at once. If the same edge captures a read and updates the same register, the read returns the pre-write value.
- ctrl_wstb[k] is high for exactly one cycle, the cycle after the update edge of ctrl[k] on an OKAY write.

Optional Feature:
STATUS_STICKY_EN
- Defined:
  - Each status bit is a register that sets when the matching stat_in bit is 1 on a clock edge.
  - Writing 1 clears that bit (W1C), honouring WSTRB, and returns OKAY.
  - Set and clear on the same edge: set wins.
  - Status registers reset to 0.
- Undefined: status reads return live stat_in, and writes return SLVERR.

Test Plan:
- Reset, then read index 0 -> RDATA=2, RRESP=0, RVALID one cycle after AR handshake.
- Write 0xA5A5_1234 to ctrl[0] (addr 0x08), WSTRB=1111, AW two cycles before W -> BRESP=0; ctrl_out[31:0]=0xA5A51234; ctrl_wstb[0] pulses once. Then write 0xFFFF_FFFF with WSTRB=0010 -> ctrl[0]=0xA5A5FF34.
- Write to unmapped addr 0x7C -> BRESP=3. Write to stat[0] without the macro -> BRESP=2, no ctrl_wstb pulse. Read 0x7C -> RRESP=3, RDATA=0.
- Hold BREADY/RREADY low 5 cycles -> BVALID/RVALID, data and resp stable; AWREADY/WREADY/ARREADY low throughout.
- Same-edge read and write of scratch (old 0x1, new 0x2) -> read returns 0x1; a subsequent read returns 0x2.
- With STATUS_STICKY_EN: pulse stat_in bit 3 for one cycle -> stat[0] reads 0x8. Write 0x8 -> reads 0x0. Write 0x8 while bit 3 is held high -> reads 0x8.

Source files
------------

// File: rtl/axil_regbank.sv
// axil_regbank: AXI4-Lite register bank with version, scratch, control and status registers.
// Define STATUS_STICKY_EN to make status bits sticky (set by stat_in, cleared by writing 1).
module axil_regbank #(
  parameter int NUM_CTRL       = 4,
  parameter int NUM_STAT       = 4,
  parameter int MODULE_VERSION = 2,
  parameter int ADDR_BITS      = 7
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [31:0]              S_AXI_AWADDR,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [2:0]               S_AXI_AWPROT,
  input  logic [31:0]              S_AXI_WDATA,
  input  logic [3:0]               S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [31:0]              S_AXI_ARADDR,
  input  logic                     S_AXI_ARVALID,
  input  logic [2:0]               S_AXI_ARPROT,
  output logic                     S_AXI_ARREADY,
  output logic [31:0]              S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,
  output logic [32*NUM_CTRL-1:0]   ctrl_out,
  output logic [NUM_CTRL-1:0]      ctrl_wstb,
  input  logic [32*NUM_STAT-1:0]   stat_in
);

  // Handshakes: a transfer happens on a rising edge where VALID and READY are both 1;
  // every READY/VALID output is a flop, so no output depends combinationally on an input.
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;
  localparam int IDX_CTRL = 2;
  localparam int IDX_STAT = 2 + NUM_CTRL;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic arready_q, arready_d, rvalid_q, rvalid_d;
  logic [ADDR_BITS-3:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d, scratch_q, scratch_d, wmask;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
  logic [NUM_CTRL-1:0][31:0] ctrl_q, ctrl_d;
  logic [NUM_CTRL-1:0]       ctrl_wstb_q, ctrl_wstb_d;
  logic [NUM_STAT-1:0][31:0] stat_live, stat_view;
  int wr_idx, rd_idx;
  logic unused_bits;

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[31:ADDR_BITS],
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[31:ADDR_BITS], S_AXI_ARADDR[1:0]};
  assign stat_live = stat_in;

`ifdef STATUS_STICKY_EN
  logic [NUM_STAT-1:0][31:0] stat_q, stat_d, stat_clr;
  // Set wins over a same-edge W1C clear.
  assign stat_d    = (stat_q & ~stat_clr) | stat_live;
  assign stat_view = stat_q;
  always_ff @(posedge clk) begin
    if (!resetn) stat_q <= '0;
    else         stat_q <= stat_d;
  end
`else
  assign stat_view = stat_live;
`endif

  always_comb begin
    w_state_d   = w_state_q;
    aw_held_d   = aw_held_q;
    w_held_d    = w_held_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    scratch_d   = scratch_q;
    ctrl_d      = ctrl_q;
    ctrl_wstb_d = '0;
`ifdef STATUS_STICKY_EN
    stat_clr    = '0;
`endif
    wr_idx = int'(awaddr_q);
    wmask  = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}}, {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};
    if (w_state_q == W_IDLE) begin
      if (S_AXI_AWVALID && awready_q) begin
        awaddr_d  = S_AXI_AWADDR[ADDR_BITS-1:2];
        aw_held_d = 1'b1;
      end
      if (S_AXI_WVALID && wready_q) begin
        wdata_d  = S_AXI_WDATA;
        wstrb_d  = S_AXI_WSTRB;
        w_held_d = 1'b1;
      end
      if (aw_held_q && w_held_q) begin
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
        bvalid_d  = 1'b1;
        w_state_d = W_RESP;
        bresp_d   = RESP_DECERR;
        if (wr_idx == 0) bresp_d = RESP_SLVERR;
        if (wr_idx == 1) begin
          bresp_d   = RESP_OKAY;
          scratch_d = (scratch_q & ~wmask) | (wdata_q & wmask);
        end
        for (int k = 0; k < NUM_CTRL; k++) begin
          if (wr_idx == IDX_CTRL + k) begin
            bresp_d        = RESP_OKAY;
            ctrl_d[k]      = (ctrl_q[k] & ~wmask) | (wdata_q & wmask);
            ctrl_wstb_d[k] = 1'b1;
          end
        end
        for (int k = 0; k < NUM_STAT; k++) begin
          if (wr_idx == IDX_STAT + k) begin
`ifdef STATUS_STICKY_EN
            bresp_d     = RESP_OKAY;
            stat_clr[k] = wdata_q & wmask;
`else
            bresp_d     = RESP_SLVERR;
`endif
          end
        end
      end
    end else if (S_AXI_BREADY) begin
      bvalid_d  = 1'b0;
      w_state_d = W_IDLE;
    end
    awready_d = (w_state_d == W_IDLE) && !aw_held_d;
    wready_d  = (w_state_d == W_IDLE) && !w_held_d;
  end

  // Reads use the current register values, so a same-edge write is not visible yet.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rd_idx    = int'(S_AXI_ARADDR[ADDR_BITS-1:2]);
    if (r_state_q == R_IDLE) begin
      if (S_AXI_ARVALID && arready_q) begin
        rvalid_d  = 1'b1;
        r_state_d = R_RESP;
        rresp_d   = RESP_DECERR;
        rdata_d   = '0;
        if (rd_idx == 0) begin
          rresp_d = RESP_OKAY;
          rdata_d = 32'(MODULE_VERSION);
        end
        if (rd_idx == 1) begin
          rresp_d = RESP_OKAY;
          rdata_d = scratch_q;
        end
        for (int k = 0; k < NUM_CTRL; k++) begin
          if (rd_idx == IDX_CTRL + k) begin
            rresp_d = RESP_OKAY;
            rdata_d = ctrl_q[k];
          end
        end
        for (int k = 0; k < NUM_STAT; k++) begin
          if (rd_idx == IDX_STAT + k) begin
            rresp_d = RESP_OKAY;
            rdata_d = stat_view[k];
          end
        end
      end
    end else if (S_AXI_RREADY) begin
      rvalid_d  = 1'b0;
      r_state_d = R_IDLE;
    end
    arready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_state_q   <= W_IDLE;
      r_state_q   <= R_IDLE;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      bresp_q     <= RESP_OKAY;
      rresp_q     <= RESP_OKAY;
      rdata_q     <= '0;
      scratch_q   <= '0;
      ctrl_q      <= '0;
      ctrl_wstb_q <= '0;
    end else begin
      w_state_q   <= w_state_d;
      r_state_q   <= r_state_d;
      aw_held_q   <= aw_held_d;
      w_held_q    <= w_held_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      bresp_q     <= bresp_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
      scratch_q   <= scratch_d;
      ctrl_q      <= ctrl_d;
      ctrl_wstb_q <= ctrl_wstb_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign ctrl_out      = ctrl_q;
  assign ctrl_wstb     = ctrl_wstb_q;

endmodule

// File: tb/tb_axil_regbank.sv
// tb_axil_regbank: randomized self-checking bench for axil_regbank against an array-based register model.
// Compile with STATUS_STICKY_EN defined to exercise the sticky status variant.
module tb_axil_regbank;
  localparam int NC = 4;
  localparam int NS = 4;

  logic clk = 1'b0;
  logic resetn;
  logic [31:0] S_AXI_AWADDR, S_AXI_WDATA, S_AXI_ARADDR, S_AXI_RDATA;
  logic S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BREADY;
  logic S_AXI_ARVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RREADY;
  logic [2:0] S_AXI_AWPROT, S_AXI_ARPROT;
  logic [3:0] S_AXI_WSTRB;
  logic [1:0] S_AXI_BRESP, S_AXI_RRESP;
  logic [32*NC-1:0] ctrl_out;
  logic [NC-1:0] ctrl_wstb;
  logic [32*NS-1:0] stat_in;

  always #5 clk = ~clk;

  axil_regbank #(.NUM_CTRL(NC), .NUM_STAT(NS), .MODULE_VERSION(2), .ADDR_BITS(7)) dut (
    .clk(clk), .resetn(resetn),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP),
    .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY), .ctrl_out(ctrl_out), .ctrl_wstb(ctrl_wstb), .stat_in(stat_in)
  );

  int checks = 0;
  int errors = 0;
  int wstb_cnt[NC];
  logic [33:0] exp_q[$];

  // Reference model: register contents as plain arrays.
  logic [31:0] m_scratch;
  logic [31:0] m_ctrl[NC];
  logic [31:0] m_sticky[NS];
  int m_wstb[NC];

  always @(negedge clk) for (int k = 0; k < NC; k++) if (ctrl_wstb[k] === 1'b1) wstb_cnt[k]++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks + 1, errors + 1);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
    return m;
  endfunction

  function automatic logic [32*NC-1:0] model_ctrl_vec();
    logic [32*NC-1:0] v;
    for (int k = 0; k < NC; k++) v[32*k +: 32] = m_ctrl[k];
    return v;
  endfunction

  function automatic logic [33:0] model_read(input int idx);
    if (idx == 0) return {2'd0, 32'd2};
    if (idx == 1) return {2'd0, m_scratch};
    if (idx >= 2 && idx < 2 + NC) return {2'd0, m_ctrl[idx-2]};
    if (idx >= 2 + NC && idx < 2 + NC + NS) begin
`ifdef STATUS_STICKY_EN
      return {2'd0, m_sticky[idx-2-NC]};
`else
      return {2'd0, stat_in[32*(idx-2-NC) +: 32]};
`endif
    end
    return {2'd3, 32'd0};
  endfunction

  task automatic model_write(input int idx, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp);
    logic [31:0] m;
    m = strb_mask(strb);
    if (idx == 0) resp = 2'd2;
    else if (idx == 1) begin
      m_scratch = (m_scratch & ~m) | (data & m);
      resp = 2'd0;
    end else if (idx < 2 + NC) begin
      m_ctrl[idx-2] = (m_ctrl[idx-2] & ~m) | (data & m);
      m_wstb[idx-2]++;
      resp = 2'd0;
    end else if (idx < 2 + NC + NS) begin
`ifdef STATUS_STICKY_EN
      m_sticky[idx-2-NC] = (m_sticky[idx-2-NC] & ~(data & m)) | stat_in[32*(idx-2-NC) +: 32];
      resp = 2'd0;
`else
      resp = 2'd2;
`endif
    end else resp = 2'd3;
  endtask

  task automatic model_reset();
    m_scratch = '0;
    for (int k = 0; k < NC; k++) m_ctrl[k] = '0;
    for (int k = 0; k < NS; k++) m_sticky[k] = '0;
  endtask

  task automatic set_stat(input logic [32*NS-1:0] v);
    stat_in = v;
    for (int k = 0; k < NS; k++) m_sticky[k] = m_sticky[k] | v[32*k +: 32];
    @(negedge clk);
  endtask

  // Driver tasks: all start and end on a falling edge.
  task automatic send_aw_w(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int cyc = 0;
    S_AXI_AWADDR = addr;
    S_AXI_WDATA  = data;
    S_AXI_WSTRB  = strb;
    while (!(aw_done && w_done) && cyc < 100) begin
      S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
      S_AXI_WVALID  = !w_done && (cyc >= w_dly);
      aw_hs = S_AXI_AWVALID && (S_AXI_AWREADY === 1'b1);
      w_hs  = S_AXI_WVALID && (S_AXI_WREADY === 1'b1);
      @(negedge clk);
      cyc++;
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
    end
    S_AXI_AWVALID = 0;
    S_AXI_WVALID  = 0;
    checks++;
    if (!(aw_done && w_done)) begin
      errors++;
      $display("FAIL aw_w_accept: aw_done=%0d w_done=%0d required both 1", aw_done, w_done);
    end
  endtask

  task automatic wait_b(output int lat);
    lat = 0;
    while (S_AXI_BVALID !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (S_AXI_BVALID !== 1'b1) begin
      errors++;
      $display("FAIL bvalid_timeout: bvalid=%b required 1", S_AXI_BVALID);
    end
  endtask

  task automatic take_b(output logic [1:0] resp);
    resp = S_AXI_BRESP;
    S_AXI_BREADY = 1;
    @(negedge clk);
    S_AXI_BREADY = 0;
  endtask

  task automatic send_ar(input logic [31:0] addr);
    bit hs = 0;
    int cyc = 0;
    S_AXI_ARADDR = addr;
    while (!hs && cyc < 100) begin
      S_AXI_ARVALID = 1;
      hs = (S_AXI_ARREADY === 1'b1);
      @(negedge clk);
      cyc++;
    end
    S_AXI_ARVALID = 0;
    checks++;
    if (!hs) begin
      errors++;
      $display("FAIL ar_accept: arready never seen");
    end
  endtask

  task automatic wait_r(output int lat);
    lat = 0;
    while (S_AXI_RVALID !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (S_AXI_RVALID !== 1'b1) begin
      errors++;
      $display("FAIL rvalid_timeout: rvalid=%b required 1", S_AXI_RVALID);
    end
  endtask

  task automatic take_r(output logic [31:0] data, output logic [1:0] resp);
    data = S_AXI_RDATA;
    resp = S_AXI_RRESP;
    S_AXI_RREADY = 1;
    @(negedge clk);
    S_AXI_RREADY = 0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, output logic [1:0] resp);
    int lat;
    send_aw_w(addr, data, strb, aw_dly, w_dly);
    wait_b(lat);
    take_b(resp);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int lat;
    send_ar(addr);
    wait_r(lat);
    take_r(data, resp);
  endtask

  task automatic test_reset();
    int lat;
    logic [31:0] d;
    logic [1:0] r;
    resetn = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID} !== 5'b0) begin
      errors++;
      $display("FAIL reset_handshake: got %b required 00000",
               {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID});
    end
    checks++;
    if ({S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, ctrl_out, ctrl_wstb} !== '0) begin
      errors++;
      $display("FAIL reset_values: bresp=%h rresp=%h rdata=%h ctrl=%h wstb=%h required all 0",
               S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, ctrl_out, ctrl_wstb);
    end
    resetn = 1;
    model_reset();
    @(negedge clk);
    send_ar(32'h0);
    wait_r(lat);
    checks++;
    if (lat !== 0) begin
      errors++;
      $display("FAIL read_latency: got %0d extra cycles required 0", lat);
    end
    take_r(d, r);
    checks++;
    if ({r, d} !== {2'd0, 32'd2}) begin
      errors++;
      $display("FAIL version_read: got resp=%0d data=%h required resp=0 data=00000002", r, d);
    end
  endtask

  task automatic test_ctrl_write();
    int lat;
    logic [1:0] r, er;
    send_aw_w(32'h08, 32'hA5A5_1234, 4'hF, 0, 2);
    model_write(2, 32'hA5A5_1234, 4'hF, er);
    wait_b(lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL write_latency: got %0d cycles required 1", lat);
    end
    take_b(r);
    @(negedge clk);
    checks++;
    if ({r, ctrl_out[31:0]} !== {2'd0, 32'hA5A5_1234} || wstb_cnt[0] !== 1) begin
      errors++;
      $display("FAIL ctrl_full_write: resp=%0d ctrl0=%h pulses=%0d required 0 a5a51234 1",
               r, ctrl_out[31:0], wstb_cnt[0]);
    end
    axi_write(32'h08, 32'hFFFF_FFFF, 4'b0010, 1, 0, r);
    model_write(2, 32'hFFFF_FFFF, 4'b0010, er);
    @(negedge clk);
    checks++;
    if ({r, ctrl_out[31:0]} !== {2'd0, 32'hA5A5_FF34} || wstb_cnt[0] !== 2) begin
      errors++;
      $display("FAIL ctrl_strobe_write: resp=%0d ctrl0=%h pulses=%0d required 0 a5a5ff34 2",
               r, ctrl_out[31:0], wstb_cnt[0]);
    end
  endtask

  task automatic test_errors();
    logic [1:0] r, er;
    logic [31:0] d;
    axi_write(32'h7C, 32'h1234_5678, 4'hF, 0, 0, r);
    model_write(31, 32'h1234_5678, 4'hF, er);
    checks++;
    if (r !== 2'd3) begin
      errors++;
      $display("FAIL unmapped_write: got resp=%0d required 3", r);
    end
    axi_write(32'h18, 32'hFFFF_FFFF, 4'hF, 2, 0, r);
    model_write(6, 32'hFFFF_FFFF, 4'hF, er);
    checks++;
    if (r !== er) begin
      errors++;
      $display("FAIL stat_write: got resp=%0d required %0d", r, er);
    end
    axi_write(32'h00, 32'hDEAD_BEEF, 4'hF, 0, 1, r);
    model_write(0, 32'hDEAD_BEEF, 4'hF, er);
    checks++;
    if (r !== 2'd2) begin
      errors++;
      $display("FAIL version_write: got resp=%0d required 2", r);
    end
    @(negedge clk);
    for (int k = 0; k < NC; k++) begin
      checks++;
      if (wstb_cnt[k] !== m_wstb[k]) begin
        errors++;
        $display("FAIL wstb_count_%0d: got %0d required %0d", k, wstb_cnt[k], m_wstb[k]);
      end
    end
    axi_read(32'h7C, d, r);
    checks++;
    if ({r, d} !== {2'd3, 32'd0}) begin
      errors++;
      $display("FAIL unmapped_read: got resp=%0d data=%h required 3 00000000", r, d);
    end
    axi_read(32'h00, d, r);
    checks++;
    if ({r, d} !== model_read(0)) begin
      errors++;
      $display("FAIL version_after_write: got resp=%0d data=%h required 0 00000002", r, d);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] wd, d;
    logic [1:0] r, er;
    logic [33:0] ex;
    wd = $urandom();
    send_aw_w(32'h04, wd, 4'hF, 1, 0);
    model_write(1, wd, 4'hF, er);
    wait_b(lat);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP} !== {3'b100, er}) begin
        errors++;
        $display("FAIL b_stall: bvalid/awready/wready/bresp=%b required %b",
                 {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP}, {3'b100, er});
      end
      @(negedge clk);
    end
    take_b(r);
    ex = model_read(1);
    send_ar(32'h04);
    wait_r(lat);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({S_AXI_RVALID, S_AXI_ARREADY, S_AXI_RRESP, S_AXI_RDATA} !== {2'b10, ex}) begin
        errors++;
        $display("FAIL r_stall: rvalid=%b arready=%b rresp=%0d rdata=%h required 1 0 %0d %h",
                 S_AXI_RVALID, S_AXI_ARREADY, S_AXI_RRESP, S_AXI_RDATA, ex[33:32], ex[31:0]);
      end
      @(negedge clk);
    end
    take_r(d, r);
  endtask

  task automatic test_same_edge();
    int lat;
    logic [31:0] d;
    logic [1:0] r, er;
    axi_write(32'h04, 32'h1, 4'hF, 0, 0, r);
    model_write(1, 32'h1, 4'hF, er);
    S_AXI_AWADDR  = 32'h04;
    S_AXI_WDATA   = 32'h2;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_AWVALID = 1;
    S_AXI_WVALID  = 1;
    @(negedge clk);
    S_AXI_AWVALID = 0;
    S_AXI_WVALID  = 0;
    S_AXI_ARADDR  = 32'h04;
    S_AXI_ARVALID = 1;
    @(negedge clk);
    S_AXI_ARVALID = 0;
    model_write(1, 32'h2, 4'hF, er);
    wait_b(lat);
    take_b(r);
    wait_r(lat);
    take_r(d, r);
    checks++;
    if ({r, d} !== {2'd0, 32'h1}) begin
      errors++;
      $display("FAIL same_edge_read: got resp=%0d data=%h required 0 00000001", r, d);
    end
    axi_read(32'h04, d, r);
    checks++;
    if ({r, d} !== model_read(1)) begin
      errors++;
      $display("FAIL after_same_edge_read: got resp=%0d data=%h required 0 00000002", r, d);
    end
  endtask

`ifdef STATUS_STICKY_EN
  task automatic test_sticky();
    logic [31:0] d;
    logic [1:0] r, er;
    set_stat('0);
    stat_in = '0;
    stat_in[3] = 1'b1;
    m_sticky[0] = m_sticky[0] | 32'h8;
    @(negedge clk);
    stat_in[3] = 1'b0;
    axi_read(32'h18, d, r);
    checks++;
    if ({r, d} !== {2'd0, 32'h8}) begin
      errors++;
      $display("FAIL sticky_set: got resp=%0d data=%h required 0 00000008", r, d);
    end
    axi_write(32'h18, 32'h8, 4'hF, 0, 0, r);
    model_write(6, 32'h8, 4'hF, er);
    axi_read(32'h18, d, r);
    checks++;
    if ({r, d} !== {2'd0, 32'h0}) begin
      errors++;
      $display("FAIL sticky_clear: got resp=%0d data=%h required 0 00000000", r, d);
    end
    set_stat(128'h8);
    axi_write(32'h18, 32'h8, 4'hF, 0, 0, r);
    model_write(6, 32'h8, 4'hF, er);
    axi_read(32'h18, d, r);
    checks++;
    if ({r, d} !== {2'd0, 32'h8}) begin
      errors++;
      $display("FAIL sticky_set_wins: got resp=%0d data=%h required 0 00000008", r, d);
    end
    stat_in = '0;
    @(negedge clk);
  endtask
`endif

  task automatic test_status();
    logic [31:0] d;
    logic [1:0] r;
    logic [33:0] ex;
    set_stat({$urandom(), $urandom(), $urandom(), $urandom()});
    for (int k = 0; k < NS; k++) begin
      exp_q.push_back(model_read(2 + NC + k));
      axi_read(32'((2 + NC + k) * 4), d, r);
      ex = exp_q.pop_front();
      checks++;
      if ({r, d} !== ex) begin
        errors++;
        $display("FAIL status_read_%0d: got resp=%0d data=%h required %0d %h", k, r, d, ex[33:32], ex[31:0]);
      end
    end
  endtask

  task automatic test_random();
    int idx;
    logic [31:0] addr, wd, d;
    logic [3:0] strb;
    logic [1:0] r, er;
    logic [33:0] ex;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 7) == 0) set_stat({$urandom(), $urandom(), $urandom(), $urandom()});
      idx  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 31)) : int'($urandom_range(0, 9));
      addr = ($urandom() & ~32'h7C) | 32'(idx << 2);
      if ($urandom_range(0, 1) == 1) begin
        wd   = $urandom();
        strb = 4'($urandom_range(0, 15));
        axi_write(addr, wd, strb, $urandom_range(0, 3), $urandom_range(0, 3), r);
        model_write(idx, wd, strb, er);
        checks++;
        if (r !== er || ctrl_out !== model_ctrl_vec()) begin
          errors++;
          $display("FAIL rand_write idx=%0d: resp=%0d ctrl=%h required %0d %h", idx, r, ctrl_out, er,
                   model_ctrl_vec());
        end
      end else begin
        exp_q.push_back(model_read(idx));
        axi_read(addr, d, r);
        ex = exp_q.pop_front();
        checks++;
        if ({r, d} !== ex) begin
          errors++;
          $display("FAIL rand_read idx=%0d: got resp=%0d data=%h required %0d %h", idx, r, d,
                   ex[33:32], ex[31:0]);
        end
      end
    end
    @(negedge clk);
    for (int k = 0; k < NC; k++) begin
      checks++;
      if (wstb_cnt[k] !== m_wstb[k]) begin
        errors++;
        $display("FAIL rand_wstb_count_%0d: got %0d required %0d", k, wstb_cnt[k], m_wstb[k]);
      end
    end
  endtask

  task automatic test_reset_abandon();
    int lat;
    logic [31:0] d;
    logic [1:0] r;
    stat_in = '0;
    send_aw_w(32'h0C, 32'h5A5A_5A5A, 4'hF, 0, 0);
    wait_b(lat);
    send_ar(32'h04);
    wait_r(lat);
    resetn = 0;
    @(negedge clk);
    checks++;
    if ({S_AXI_BVALID, S_AXI_RVALID} !== 2'b00 || ctrl_out !== '0) begin
      errors++;
      $display("FAIL reset_abandon: bvalid=%b rvalid=%b ctrl=%h required 0 0 0", S_AXI_BVALID,
               S_AXI_RVALID, ctrl_out);
    end
    resetn = 1;
    model_reset();
    @(negedge clk);
    axi_read(32'h04, d, r);
    checks++;
    if ({r, d} !== model_read(1)) begin
      errors++;
      $display("FAIL scratch_after_reset: got resp=%0d data=%h required 0 00000000", r, d);
    end
  endtask

  initial begin
    resetn = 0;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 0; S_AXI_AWPROT = '0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
    S_AXI_ARADDR = '0; S_AXI_ARVALID = 0; S_AXI_ARPROT = '0; S_AXI_RREADY = 0;
    stat_in = '0;
    model_reset();
    for (int k = 0; k < NC; k++) m_wstb[k] = 0;
    @(negedge clk);
    test_reset();
    test_ctrl_write();
    test_errors();
    test_backpressure();
    test_same_edge();
`ifdef STATUS_STICKY_EN
    test_sticky();
`endif
    test_status();
    test_random();
    test_reset_abandon();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
